// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port ids, word byte layout.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DC = 1'b1;

  typedef logic [7:0] byte4_t [0:3];

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between ifetch (port 0) and dcache (port 1).
// MEM_ARB_FIXED_PRIO_EN: dcache always wins a tie; otherwise round-robin on last_grant.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dc_req,
  input  logic last_grant,
  output logic any_req,
  output logic pick
);

  assign any_req = if_req | dc_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign pick = dc_req ? PORT_DC : PORT_IF;
`else
  always_comb begin
    pick = dc_req ? PORT_DC : PORT_IF;
    if (if_req && dc_req) pick = ~last_grant;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises ifetch and dcache word transactions onto one memory port.
// Arbitration policy is selected in arb_pick via MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output byte4_t      if_rdata,
  output logic        if_done,
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  input  byte4_t      dc_wdata,
  output byte4_t      dc_rdata,
  output logic        dc_done,
  output logic [31:0] mem_addr,
  output byte4_t      mem_data_in,
  input  byte4_t      mem_data_out,
  output logic        mem_write_en,
  output logic        busy
);

  localparam int CW = 4;

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          win;
  logic          we_q;
  logic          any_req;
  logic          pick;
  logic          pick_we;

  arb_pick u_pick (
    .if_req     (if_req),
    .dc_req     (dc_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .pick       (pick)
  );

  assign pick_we = (pick == PORT_DC) && dc_we;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= PORT_DC;
      win          <= PORT_IF;
      we_q         <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '{default: 8'h00};
      mem_write_en <= 1'b0;
      if_done      <= 1'b0;
      dc_done      <= 1'b0;
      if_rdata     <= '{default: 8'h00};
      dc_rdata     <= '{default: 8'h00};
    end else begin
      if_done      <= 1'b0;
      dc_done      <= 1'b0;
      mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            win      <= pick;
            we_q     <= pick_we;
            mem_addr <= (pick == PORT_DC) ? dc_addr : if_addr;
            for (int i = 0; i < 4; i++)
              mem_data_in[i] <= pick_we ? dc_wdata[i] : 8'h00;
            cnt          <= CW'(MEM_LATENCY - 1);
            // strobe is registered, so it is raised one edge ahead of the final BUSY cycle
            mem_write_en <= pick_we && (MEM_LATENCY == 1);
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt          <= cnt - CW'(1);
            mem_write_en <= we_q && (cnt == CW'(1));
          end else begin
            if (!we_q) begin
              if (win == PORT_DC) dc_rdata <= mem_data_out;
              else                if_rdata <= mem_data_out;
            end
            if (win == PORT_DC) dc_done <= 1'b1;
            else                if_done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          last_grant <= win;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plus directed and random stimulus.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ML = 3;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  logic        if_req, if_done, dc_req, dc_we, dc_done, mem_write_en, busy;
  logic [31:0] if_addr, dc_addr, mem_addr;
  byte4_t      if_rdata, dc_rdata, dc_wdata, mem_data_in, mem_data_out;

  logic        f_if_req, f_if_done, f_dc_req, f_dc_we, f_dc_done, f_mem_write_en, f_busy;
  logic [31:0] f_if_addr, f_dc_addr, f_mem_addr;
  byte4_t      f_if_rdata, f_dc_rdata, f_dc_wdata, f_mem_data_in, f_mem_data_out;

  mem_arbiter #(.MEM_LATENCY(ML)) dut (
    .clk(clk), .rst_b(rst_b),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .busy(busy)
  );

  mem_arbiter #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_b(rst_b),
    .if_req(f_if_req), .if_addr(f_if_addr), .if_rdata(f_if_rdata), .if_done(f_if_done),
    .dc_req(f_dc_req), .dc_we(f_dc_we), .dc_addr(f_dc_addr), .dc_wdata(f_dc_wdata),
    .dc_rdata(f_dc_rdata), .dc_done(f_dc_done),
    .mem_addr(f_mem_addr), .mem_data_in(f_mem_data_in), .mem_data_out(f_mem_data_out),
    .mem_write_en(f_mem_write_en), .busy(f_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input byte4_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Environment memory: combinational-looking read refreshed each negedge, write on strobe.
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always @(negedge clk) begin : mem_rd
    logic [31:0] w, fw;
    w  = env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr);
    fw = env_mem.exists(f_mem_addr) ? env_mem[f_mem_addr] : dflt(f_mem_addr);
    for (int i = 0; i < 4; i++) begin
      mem_data_out[i]   = w[31-8*i -: 8];
      f_mem_data_out[i] = fw[31-8*i -: 8];
    end
  end
  always @(posedge clk) if (mem_write_en === 1'b1) env_mem[mem_addr] = pk(mem_data_in);

  // Reference model: one transaction at a time, sampled on the edge after the previous one retires.
  int          cyc;
  bit          m_busy, m_port, m_lg, m_we;
  logic [31:0] m_addr, m_wdata, e_if_rd, e_dc_rd;
  int          m_start;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cyc = 0; m_busy = 0; m_lg = 1; m_start = 0; e_if_rd = '0; e_dc_rd = '0;
    end else begin
      cyc++;
      if (m_busy) begin
        if (cyc == m_start + ML) begin
          if (m_we) ref_mem[m_addr] = m_wdata;
          else if (m_port) e_dc_rd = ref_rd(m_addr);
          else e_if_rd = ref_rd(m_addr);
        end else if (cyc == m_start + ML + 1) m_busy = 0;
      end else if (if_req || dc_req) begin
        if (if_req && dc_req) m_port = FIXED ? 1'b1 : ~m_lg;
        else m_port = dc_req;
        m_lg    = m_port;
        m_we    = m_port && dc_we;
        m_addr  = m_port ? dc_addr : if_addr;
        m_wdata = m_we ? pk(dc_wdata) : 32'h0;
        m_start = cyc;
        m_busy  = 1;
      end
    end
  end

  int          if_cnt = 0, dc_cnt = 0, we_cnt = 0, f_we_cnt = 0;
  int          we_cyc = 0, dcd_cyc = 0;
  logic [31:0] we_addr, we_data;

  always @(negedge clk) begin : monitor
    bit e_done, e_we;
    e_done = m_busy && (cyc == m_start + ML);
    e_we   = m_busy && m_we && (cyc == m_start + ML - 1);
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("if_done", {31'b0, if_done}, {31'b0, e_done && !m_port});
    chk("dc_done", {31'b0, dc_done}, {31'b0, e_done && m_port});
    chk("mem_write_en", {31'b0, mem_write_en}, {31'b0, e_we});
    chk("if_rdata", pk(if_rdata), e_if_rd);
    chk("dc_rdata", pk(dc_rdata), e_dc_rd);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_data_in", pk(mem_data_in), m_wdata);
    end
    if (!rst_b) begin
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_data_in", pk(mem_data_in), 32'h0);
    end
    if (if_done) if_cnt++;
    if (dc_done) begin dc_cnt++; dcd_cyc = cyc; end
    if (mem_write_en) begin we_cnt++; we_cyc = cyc; we_addr = mem_addr; we_data = pk(mem_data_in); end
    if (f_mem_write_en) f_we_cnt++;
  end

  task automatic wait_done(input bit port, output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk); #1;
      if ((port ? dc_done : if_done) === 1'b1) begin n = k; return; end
    end
  endtask

  initial begin : stim
    int n, c0, c1, tick, nd;
    int d_port[$];
    int d_tick[$];
    logic [31:0] wr;
    if_req = 0; if_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '{default: 8'h00};
    f_if_req = 0; f_if_addr = '0; f_dc_req = 0; f_dc_we = 0; f_dc_addr = '0;
    f_dc_wdata = '{default: 8'h00};
    env_mem[32'h10] = 32'h1300_0000;
    ref_mem[32'h10] = 32'h1300_0000;
    #1 rst_b = 0;
    repeat (3) @(negedge clk);
    #2 rst_b = 1;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_if_rdata", pk(if_rdata), 32'h0);

    // Tie: both ports request continuously
    @(negedge clk); #1;
    if_addr = 32'h20; dc_addr = 32'h40; if_req = 1; dc_req = 1;
    tick = 0;
    while (d_port.size() < 4 && tick < 60) begin
      @(negedge clk); #1; tick++;
      if (if_done) begin d_port.push_back(0); d_tick.push_back(tick); if_addr += 4; end
      if (dc_done) begin d_port.push_back(1); d_tick.push_back(tick); dc_addr += 4; end
    end
    if_req = 0; dc_req = 0;
    chk("tie_count", d_port.size(), 4);
    for (int i = 0; i < d_port.size() && i < 4; i++)
      chk("tie_grant", d_port[i], FIXED ? 1 : i % 2);
    for (int i = 1; i < d_tick.size(); i++)
      chk("tie_spacing", d_tick[i] - d_tick[i-1], ML + 2);

    // Write then read back through the other port
    repeat (3) @(negedge clk); #1;
    c0 = we_cnt;
    dc_we = 1; dc_addr = 32'h100; dc_wdata = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; dc_req = 1;
    wait_done(1, n);
    dc_req = 0; dc_we = 0;
    chk("wr_latency", n, ML + 1);
    chk("wr_strobes", we_cnt - c0, 1);
    chk("wr_addr", we_addr, 32'h100);
    chk("wr_data", we_data, 32'hAABB_CCDD);
    chk("wr_then_done", dcd_cyc - we_cyc, 1);
    @(negedge clk); #1;
    if_addr = 32'h100; if_req = 1;
    wait_done(0, n);
    if_req = 0;
    chk("rd_latency", n, ML + 1);
    chk("rd_back", pk(if_rdata), 32'hAABB_CCDD);

    // Dropped request mid-BUSY still completes once
    repeat (2) @(negedge clk); #1;
    c0 = dc_cnt;
    dc_addr = 32'h44; dc_req = 1;
    repeat (2) @(negedge clk); #1;
    dc_req = 0;
    repeat (10) @(negedge clk); #1;
    chk("drop_done", dc_cnt - c0, 1);

    // Reset in the middle of a transaction
    if_addr = 32'h48; if_req = 1;
    repeat (2) @(negedge clk); #1;
    chk("pre_rst_busy", {31'b0, busy}, 32'h1);
    c0 = if_cnt; c1 = we_cnt;
    rst_b = 0; if_req = 0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_if_rdata", pk(if_rdata), 32'h0);
    chk("rst_mem_addr_now", mem_addr, 32'h0);
    repeat (4) @(negedge clk); #1;
    chk("rst_no_done", if_cnt - c0, 0);
    chk("rst_no_strobe", we_cnt - c1, 0);
    rst_b = 1;

    // Random traffic against the reference model
    for (int t = 0; t < 500; t++) begin
      @(negedge clk); #1;
      if (if_req) begin
        if (if_done) begin
          if ($urandom_range(0, 2) == 0) if_addr = 32'h1000 + ($urandom_range(0, 15) << 2);
          else if_req = 0;
        end else if ($urandom_range(0, 40) == 0) if_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_addr = 32'h1000 + ($urandom_range(0, 15) << 2); if_req = 1;
      end
      if (dc_req) begin
        if (dc_done) begin
          if ($urandom_range(0, 2) == 0) begin
            dc_we = 1'($urandom); dc_addr = 32'h1000 + ($urandom_range(0, 15) << 2);
            for (int i = 0; i < 4; i++) dc_wdata[i] = 8'($urandom);
          end else dc_req = 0;
        end else if ($urandom_range(0, 40) == 0) dc_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        dc_we = 1'($urandom); dc_addr = 32'h1000 + ($urandom_range(0, 15) << 2);
        for (int i = 0; i < 4; i++) dc_wdata[i] = 8'($urandom);
        dc_req = 1;
      end
    end
    if_req = 0; dc_req = 0;
    repeat (12) @(negedge clk); #1;
    chk("rand_idle", {31'b0, busy}, 32'h0);

    // MEM_LATENCY=1 instance: single read and single write
    f_if_addr = 32'h10; f_if_req = 1;
    n = -1;
    for (int k = 1; k <= 10 && n < 0; k++) begin @(negedge clk); #1; if (f_if_done) n = k; end
    f_if_req = 0;
    chk("l1_rd_latency", n, 2);
    chk("l1_rd_data", pk(f_if_rdata), 32'h1300_0000);
    chk("l1_rd_no_strobe", f_we_cnt, 0);
    @(negedge clk); #1;
    f_dc_we = 1; f_dc_addr = 32'h100; f_dc_wdata = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; f_dc_req = 1;
    n = -1; nd = 0; wr = '0;
    for (int k = 1; k <= 10 && n < 0; k++) begin
      @(negedge clk); #1;
      if (f_mem_write_en) begin
        nd++;
        chk("l1_wr_addr", f_mem_addr, 32'h100);
        wr = pk(f_mem_data_in);
      end
      if (f_dc_done) n = k;
    end
    f_dc_req = 0; f_dc_we = 0;
    chk("l1_wr_latency", n, 2);
    chk("l1_wr_strobes", nd, 1);
    chk("l1_wr_data", wr, 32'hAABB_CCDD);
    repeat (3) @(negedge clk); #1;
    chk("l1_wr_strobe_total", f_we_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single main-memory port between the core's instruction-fetch path (port 0, read-only) and the data cache refill/write-back path (port 1, read/write). It sits between the core/cache and the memory model, serialises whole-word transactions, and returns each requester a one-cycle completion pulse with read data. Arbitration is round-robin by default, with fixed priority as a compile-time option.

## Interface
- MEM_LATENCY, 1: cycles the memory needs with address held before read data is valid or a write is committed; legal range 1..15
- clk  input  1  clock; all state updates on posedge
- rst_b  input  1  asynchronous, active-low reset
- if_req  input  1  port 0 request; held high until if_done
- if_addr  input  32  port 0 word address; byte offset ignored
- if_rdata  output  8x[0:3]  port 0 read data, valid in the if_done cycle
- if_done  output  1  port 0 completion pulse, one cycle
- dc_req  input  1  port 1 request; held high until dc_done
- dc_we  input  1  port 1 write (1) or read (0)
- dc_addr  input  32  port 1 word address
- dc_wdata  input  8x[0:3]  port 1 write bytes
- dc_rdata  output  8x[0:3]  port 1 read data, valid in the dc_done cycle
- dc_done  output  1  port 1 completion pulse, one cycle
- mem_addr  output  32  memory address
- mem_data_in  output  8x[0:3]  memory write bytes
- mem_data_out  input  8x[0:3]  memory read bytes
- mem_write_en  output  1  memory write strobe
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any request is high, select a winner and latch its addr, we, and wdata; set cnt = MEM_LATENCY-1; go to BUSY. Port 0 always has we = 0.
- BUSY: mem_addr drives the latched address, and mem_data_in drives the latched wdata for writes and 0 otherwise.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: for a write, assert mem_write_en for this single cycle; for a read, capture mem_data_out into the winner's rdata register. Go to DONE.
- DONE: pulse the winner's done output, update last_grant to the winner, and return to IDLE.
- Round-robin: if only one port requests, it wins. If both request, the winner is the port that is not last_grant. last_grant resets to 1, so port 0 wins the first tie.
- Requests are sampled only in IDLE. A req that drops mid-transaction has no effect; the transaction completes and done still pulses.
- rdata registers hold their value until overwritten by the next read on the same port.
- Reset mid-transaction aborts immediately. No done pulse is issued and no write strobe is generated.

## Timing
- Reset values:
  - state IDLE, cnt 0, last_grant 1
  - mem_addr 0, mem_data_in all 0, mem_write_en 0
  - if_done and dc_done 0
  - if_rdata and dc_rdata all 0
  - busy 0
- Latency from the cycle req is sampled in IDLE to the done pulse is MEM_LATENCY+1 cycles. With MEM_LATENCY=1: sample at cycle T, BUSY at T+1, done at T+2.
- Back-to-back throughput is one transaction per MEM_LATENCY+2 cycles, because the arbiter re-samples in the IDLE cycle after DONE.
- A requester may keep req high through the done cycle to issue its next transaction. Under contention it then loses the next tie to the other port.
- mem_addr and mem_data_in are registered and stable for all BUSY cycles. mem_write_en is high for exactly one cycle per write.
- done pulses are registered and last exactly one cycle. if_done and dc_done are never high in the same cycle.

## Configuration
- MEM_ARB_FIXED_PRIO_EN defined: port 1 (dcache) always wins when both ports request. last_grant is not used, and port 0 can be starved.
- MEM_ARB_FIXED_PRIO_EN undefined: the round-robin scheme above.

## Structure
- mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t
  - localparams PORT_IF = 1'b0 and PORT_DC = 1'b1
  - typedef logic [7:0] byte4_t [0:3]
- One sub-module, arb_pick: combinational winner select from if_req, dc_req, and last_grant. It holds the MEM_ARB_FIXED_PRIO_EN ifdef so the FSM is unaffected by the option.

## Test plan
- Reset: assert rst_b=0 mid-BUSY -> all outputs return to their reset values, no done pulse, busy=0.
- Single read: MEM_LATENCY=1, if_req with if_addr=0x10, memory returns bytes {0x13,0x00,0x00,0x00} -> if_done two cycles after sampling, if_rdata={0x13,0,0,0}, mem_write_en never high.
- Write: dc_we=1, dc_addr=0x100, dc_wdata={0xAA,0xBB,0xCC,0xDD} -> mem_write_en high for exactly one cycle with mem_addr=0x100 and mem_data_in equal to the wdata, followed by dc_done.
- Tie: both ports requesting continuously with MEM_LATENCY=3 -> grants alternate 0,1,0,1; each done arrives 5 cycles after the previous one.
- Fixed priority: with MEM_ARB_FIXED_PRIO_EN defined and both ports requesting continuously -> every grant goes to dc and if_done never pulses.
- Dropped request: drop dc_req during BUSY -> the transaction completes and dc_done still pulses once.
